// File: rtl/sprite_bitmap_loader.sv
// -----------------------------------------------------------------------------
// sprite_bitmap_loader
//
// Double-buffered 8-bit sprite bitmap RAM. The host streams bytes into the back
// bank through a valid/ready handshake. A commit request swaps the banks on the
// next vsync rising edge, so the renderer never sees a half-updated frame. The
// new back bank is then refreshed by copying the new front bank into it, one
// byte per clock.
//
// Optional build macro: SPRITE_BITMAP_LOADER_READBACK_EN
//   When defined, adds rd_back_data = back[wr_addr] so the host can verify its
//   writes before committing. It reads 0 whenever a commit is in flight.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous active-low reset
//   vsync        in   vertical sync, any phase relative to clk
//   wr_valid     in   host write request
//   wr_ready     out  write can be accepted (state is IDLE)
//   wr_addr      in   host write address in the back bank
//   wr_data      in   host write data
//   commit       in   request a bank swap at the next vsync rising edge
//   busy         out  commit pending or copy running
//   commit_done  out  one-cycle pulse after swap and copy complete
//   front_bank   out  index of the displayed bank
//   rd_addr      in   renderer read address
//   rd_data      out  front-bank byte at rd_addr, zero latency
//   rd_back_data out  back-bank byte at wr_addr (readback build only)
// -----------------------------------------------------------------------------
module sprite_bitmap_loader #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 commit,
  output logic                 busy,
  output logic                 commit_done,
  output logic                 front_bank,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
`ifdef SPRITE_BITMAP_LOADER_READBACK_EN
  ,
  output logic [7:0]           rd_back_data
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COPY    = 2'd2;

  localparam int MEM_WORDS = 2 ** (ADDR_BITS + 1);

  logic [1:0]           state_q, state_d;
  logic                 front_q, front_d;
  logic                 vsync_q;
  logic [ADDR_BITS-1:0] copy_idx_q, copy_idx_d;
  logic                 commit_done_q, commit_done_d;

  logic                 vsync_rise;
  logic                 copy_last;

  // Both banks live in one array; the bank index is the top address bit.
  logic [7:0]           bank_mem [0:MEM_WORDS-1];
  logic                 mem_we;
  logic [ADDR_BITS:0]   mem_waddr;
  logic [7:0]           mem_wdata;
  logic                 host_we;
  logic                 copy_we;

  assign vsync_rise = vsync & ~vsync_q;
  // Completion is taken from the all-ones index, not from the wrap to zero.
  assign copy_last  = (copy_idx_q == {ADDR_BITS{1'b1}});

  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    copy_idx_d    = copy_idx_q;
    commit_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // A level that was already high when commit arrived has vsync_q set,
        // so it cannot trigger; only a fresh 0->1 transition swaps.
        if (vsync_rise) begin
          front_d    = ~front_q;
          copy_idx_d = '0;
          state_d    = ST_COPY;
        end
      end
      ST_COPY: begin
        copy_idx_d = copy_idx_q + 1'b1;
        if (copy_last) begin
          state_d       = ST_IDLE;
          commit_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      front_q       <= 1'b0;
      vsync_q       <= 1'b0;
      copy_idx_q    <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      vsync_q       <= vsync;
      copy_idx_q    <= copy_idx_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign wr_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign commit_done = commit_done_q;
  assign front_bank  = front_q;

  // Host writes and the refresh copy never overlap: the host only writes in
  // IDLE, the copy only runs in COPY. Both always target the back bank.
  assign host_we   = wr_valid && (state_q == ST_IDLE);
  assign copy_we   = (state_q == ST_COPY);
  assign mem_we    = host_we | copy_we;
  assign mem_waddr = copy_we ? {~front_q, copy_idx_q} : {~front_q, wr_addr};
  assign mem_wdata = copy_we ? bank_mem[{front_q, copy_idx_q}] : wr_data;

  // Bank contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      bank_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data = bank_mem[{front_q, rd_addr}];

`ifdef SPRITE_BITMAP_LOADER_READBACK_EN
  assign rd_back_data = (state_q == ST_IDLE) ? bank_mem[{~front_q, wr_addr}] : 8'h00;
`endif

endmodule

// File: tb/tb_sprite_bitmap_loader.sv
module tb_sprite_bitmap_loader;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       busy;
  logic       commit_done;
  logic       front_bank;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
`ifdef SPRITE_BITMAP_LOADER_READBACK_EN
  logic [7:0] rd_back_data;
`endif

  int total = 0;
  int bad   = 0;

  sprite_bitmap_loader #(.ADDR_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .busy        (busy),
    .commit_done (commit_done),
    .front_bank  (front_bank),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`ifdef SPRITE_BITMAP_LOADER_READBACK_EN
    ,
    .rd_back_data(rd_back_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    $display("write addr=0x%02h data=0x%02h", a, d);
  endtask

  // Runs until busy drops (bounded), then a few extra cycles, counting pulses.
  task automatic run_to_idle(output int pulses, output bit timeout);
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (commit_done === 1'b1) pulses++;
      if (busy === 1'b0) break;
    end
    timeout = (busy !== 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (commit_done === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    total++;
    if ({wr_ready, busy, front_bank, commit_done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_state: got ready/busy/front/done=%b required 1000",
               {wr_ready, busy, front_bank, commit_done});
    end
    $display("reset released: ready=%b busy=%b front=%b done=%b",
             wr_ready, busy, front_bank, commit_done);
  endtask

  task automatic test_basic_commit();
    int pulses;
    bit to;
    int busy_low;
    host_write(8'h05, 8'hA5);
    host_write(8'h10, 8'h3C);
    rd_addr = 8'h05;
    #1;
    total++;
    if (rd_data === 8'hA5) begin
      bad++;
      $display("FAIL basic_no_early_visibility: got rd_data=0x%02h required not 0xA5", rd_data);
    end
    commit = 1'b1;
    step();
    commit = 1'b0;
    $display("commit issued");
    total++;
    if ({busy, wr_ready} !== 2'b10) begin
      bad++;
      $display("FAIL basic_pending_flags: got busy/ready=%b required 10", {busy, wr_ready});
    end
    busy_low = 0;
    repeat (19) begin
      step();
      if (busy !== 1'b1 || wr_ready !== 1'b0 || front_bank !== 1'b0) busy_low++;
    end
    total++;
    if (busy_low != 0) begin
      bad++;
      $display("FAIL basic_pending_hold: got %0d bad cycles required 0", busy_low);
    end
    vsync = 1'b1;
    step();
    total++;
    if (front_bank !== 1'b1 || rd_data !== 8'hA5) begin
      bad++;
      $display("FAIL basic_swap: got front=%b rd=0x%02h required front=1 rd=0xA5",
               front_bank, rd_data);
    end
    $display("vsync edge: front=%b rd[0x05]=0x%02h", front_bank, rd_data);
    // After the toggle edge 255 more edges keep busy high, the 256th ends COPY.
    busy_low = 0;
    for (int k = 1; k <= 255; k++) begin
      step();
      if (k == 10) vsync = 1'b0;
      if (busy !== 1'b1 || commit_done !== 1'b0) busy_low++;
    end
    total++;
    if (busy_low != 0) begin
      bad++;
      $display("FAIL basic_copy_length: got %0d early-idle cycles required 0", busy_low);
    end
    step();
    total++;
    if (busy !== 1'b0 || commit_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_commit_done: got busy=%b done=%b required busy=0 done=1",
               busy, commit_done);
    end
    run_to_idle(pulses, to);
    total++;
    if (pulses != 0 || to) begin
      bad++;
      $display("FAIL basic_single_pulse: got %0d extra pulses required 0", pulses);
    end
    rd_addr = 8'h10;
    #1;
    total++;
    if (rd_data !== 8'h3C) begin
      bad++;
      $display("FAIL basic_rd_10: got 0x%02h required 0x3C", rd_data);
    end
  endtask

  task automatic test_copy_preservation();
    int pulses;
    bit to;
    host_write(8'h05, 8'h77);
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (5) step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    total++;
    if (front_bank !== 1'b0) begin
      bad++;
      $display("FAIL preserve_front: got %b required 0", front_bank);
    end
    run_to_idle(pulses, to);
    total++;
    if (pulses != 1 || to) begin
      bad++;
      $display("FAIL preserve_pulses: got %0d timeout=%0b required 1 pulse", pulses, to);
    end
    rd_addr = 8'h05;
    #1;
    total++;
    if (rd_data !== 8'h77) begin
      bad++;
      $display("FAIL preserve_rd_05: got 0x%02h required 0x77", rd_data);
    end
    rd_addr = 8'h10;
    #1;
    total++;
    if (rd_data !== 8'h3C) begin
      bad++;
      $display("FAIL preserve_rd_10: got 0x%02h required 0x3C", rd_data);
    end
    $display("copy preservation: front=%b rd[0x10]=0x%02h", front_bank, rd_data);
  endtask

  task automatic test_vsync_high();
    int pulses;
    bit to;
    int wrong;
    vsync = 1'b1;
    repeat (3) step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    wrong = 0;
    repeat (10) begin
      step();
      if (front_bank !== 1'b0 || busy !== 1'b1) wrong++;
    end
    total++;
    if (wrong != 0) begin
      bad++;
      $display("FAIL vsync_high_no_toggle: got %0d toggled cycles required 0", wrong);
    end
    vsync = 1'b0;
    step();
    total++;
    if (front_bank !== 1'b0) begin
      bad++;
      $display("FAIL vsync_fall_no_toggle: got front=%b required 0", front_bank);
    end
    vsync = 1'b1;
    step();
    total++;
    if (front_bank !== 1'b1) begin
      bad++;
      $display("FAIL vsync_rerise_toggle: got front=%b required 1", front_bank);
    end
    vsync = 1'b0;
    run_to_idle(pulses, to);
    total++;
    if (pulses != 1 || to) begin
      bad++;
      $display("FAIL vsync_high_pulses: got %0d required 1", pulses);
    end
    $display("vsync already high: swap after re-rise, front=%b", front_bank);
  endtask

  task automatic test_same_cycle();
    int pulses;
    bit to;
    wr_valid = 1'b1;
    wr_addr  = 8'h20;
    wr_data  = 8'h99;
    commit   = 1'b1;
    step();
    wr_valid = 1'b0;
    commit   = 1'b0;
    $display("write addr=0x20 data=0x99 with commit");
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    rd_addr = 8'h20;
    #1;
    total++;
    if (front_bank !== 1'b0 || rd_data !== 8'h99) begin
      bad++;
      $display("FAIL same_cycle_write: got front=%b rd=0x%02h required front=0 rd=0x99",
               front_bank, rd_data);
    end
    run_to_idle(pulses, to);
    total++;
    if (pulses != 1 || to) begin
      bad++;
      $display("FAIL second_commit_ignored: got %0d pulses required 1", pulses);
    end
    // A commit ignored in PENDING must not leave a second swap queued.
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || front_bank !== 1'b0) begin
      bad++;
      $display("FAIL no_queued_commit: got busy=%b front=%b required 0 0", busy, front_bank);
    end
  endtask

  task automatic test_reset_mid_copy();
    commit = 1'b1;
    step();
    commit = 1'b0;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    repeat (100) step();
    reset = 1'b0;
    #1;
    total++;
    if ({wr_ready, busy, front_bank, commit_done} !== 4'b1000) begin
      bad++;
      $display("FAIL async_reset_mid_copy: got ready/busy/front/done=%b required 1000",
               {wr_ready, busy, front_bank, commit_done});
    end
    #2;
    reset = 1'b1;
    step();
    total++;
    if ({wr_ready, busy, front_bank} !== 3'b100) begin
      bad++;
      $display("FAIL after_reset_idle: got ready/busy/front=%b required 100",
               {wr_ready, busy, front_bank});
    end
    $display("reset at copy cycle 100: ready=%b front=%b", wr_ready, front_bank);
`ifdef SPRITE_BITMAP_LOADER_READBACK_EN
    host_write(8'h30, 8'h5A);
    wr_addr = 8'h30;
    #1;
    total++;
    if (rd_back_data !== 8'h5A) begin
      bad++;
      $display("FAIL readback: got 0x%02h required 0x5A", rd_back_data);
    end
`endif
  endtask

  initial begin
    reset    = 1'b0;
    vsync    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 8'h00;
    wr_data  = 8'h00;
    commit   = 1'b0;
    rd_addr  = 8'h00;
    test_reset();
    test_basic_commit();
    test_copy_preservation();
    test_vsync_high();
    test_same_cycle();
    test_reset_mid_copy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_bitmap_loader.md
Name: sprite_bitmap_loader

Overview:
- Writer-side counterpart to the sprite renderers. Owns a double-buffered 8-bit sprite bitmap RAM.
- A host (CPU or test sequencer) streams bytes into the back bank through a valid/ready handshake.
- A commit request swaps banks on the next vsync rising edge, so updates never tear mid-frame. The new back bank is then refreshed by copying the new front bank into it.
- The renderer side reads the front bank through the same 8-bit addr/bits combinational port the bitmap ROMs present.

Parameters:
- ADDR_BITS, 8, bank address width. Bank depth is 2**ADDR_BITS bytes; the default holds 8 bitmaps of 16x16 (32 bytes each).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- vsync  in  1  vertical sync from hvsync_generator; any phase relative to clk
- wr_valid  in  1  host write request
- wr_ready  out  1  high when a write can be accepted
- wr_addr  in  ADDR_BITS  host write address (back bank)
- wr_data  in  8  host write data
- commit  in  1  request a bank swap at the next vsync rising edge
- busy  out  1  high while a commit is pending or a copy is running
- commit_done  out  1  one-cycle pulse when the swap and copy have completed
- front_bank  out  1  index of the bank currently displayed
- rd_addr  in  ADDR_BITS  renderer read address
- rd_data  out  8  front-bank byte at rd_addr, combinational (zero latency)

Behaviour:
- Reset (reset low, async): state=IDLE, front_bank=0, vsync_q=0, copy_idx=0, commit_done=0. Bank RAM contents are not reset and are undefined until written.
- wr_ready = (state==IDLE); busy = (state!=IDLE). Both are combinational from state.
- Write accept: when wr_valid && wr_ready at a rising clk edge, back[wr_addr] <= wr_data. back = bank !front_bank.
- Read: rd_data = front[rd_addr], combinational. Back-bank writes are never visible on rd_data before the swap.
- vsync_rise = vsync && !vsync_q, where vsync_q is vsync registered every clk. Only rising edges count; a level that is already high does not.
- IDLE:
  - commit=1 -> PENDING.
  - A write presented in the same cycle as commit is accepted and is included in the commit.
- PENDING:
  - wr_ready=0; commit is ignored.
  - On the clk edge where vsync_rise=1: front_bank toggles, copy_idx<=0, state -> COPY.
  - If vsync is already high when commit arrives, wait for it to fall and rise again.
- COPY:
  - Each cycle: back[copy_idx] <= front[copy_idx] (the new front/back after the toggle); copy_idx++.
  - On the cycle copy_idx==2**ADDR_BITS-1, the last byte is copied and state -> IDLE.
  - commit_done is registered: high for exactly the first cycle back in IDLE.
  - COPY lasts exactly 2**ADDR_BITS cycles. vsync edges during COPY are ignored.
- copy_idx is ADDR_BITS wide. Completion is detected on the all-ones value, not on wrap.
- Reset mid-PENDING or mid-COPY: aborts immediately to IDLE with front_bank=0. A partially copied back bank is left as-is, and its contents are undefined to the host.
- Latency: from vsync rising at the input to rd_data reflecting the new bank is 1 clk (the toggle edge).

Optional Feature:
- Macro: SPRITE_BITMAP_LOADER_READBACK_EN.
- Defined:
  - Adds output port rd_back_data [7:0] = back[wr_addr], combinational.
  - Valid whenever state==IDLE; driven 0 otherwise.
  - Lets the host verify its writes before committing.
- Undefined: the port is absent and no extra read path is built.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> wr_ready=1, busy=0, front_bank=0, commit_done=0. Pulse reset=0 asynchronously mid-cycle -> outputs return to these values without waiting for a clk edge.
- Basic commit:
  - Stimulus: write 0x05=0xA5 and 0x10=0x3C; rd_addr=0x05 before commit; pulse commit; vsync rises 20 cycles later.
  - Before commit, rd_data != 0xA5 from the write, since the write went to the back bank.
  - After commit, busy=1 and wr_ready=0 until the vsync edge. One clk after the edge, front_bank=1 and rd_data=0xA5.
  - busy stays high for 256 copy cycles, then commit_done pulses once.
- Vsync already high: commit while vsync=1 -> no toggle until vsync goes 0 then 1; front_bank unchanged during the high level.
- Copy preservation:
  - Stimulus: after the basic-commit scenario, write 0x05=0x77 only, then commit with a vsync edge.
  - Required: rd 0x05=0x77 and rd 0x10=0x3C (copied byte preserved); front_bank back to 0.
- Commit plus write in the same IDLE cycle, with wr_addr=0x20 and wr_data=0x99 -> the write is accepted and rd 0x20=0x99 after the swap. A second commit during PENDING is ignored: only one commit_done pulse.
- Reset at copy cycle 100 -> immediately state IDLE, front_bank=0, wr_ready=1. With READBACK_EN: writing 0x30=0x5A gives rd_back_data=0x5A with wr_addr=0x30.
